cdc_handshake_sender: RTL and testbench

//  Source-domain half of a 4-phase req/ack bus crossing. Captures a data word on a valid/ready

---
 rtl/cdc_hs_pkg.sv | 22 ++
 rtl/cdc_sync_2ff.sv | 24 ++
 rtl/cdc_handshake_sender.sv | 133 +++++++++++++
 tb/tb_cdc_handshake_sender.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
// Shared types and helpers for the source-side req/ack bus crossing.
// Holds the handshake state encoding and the timer-width calculation.
// No logic of its own; imported by cdc_handshake_sender.
package cdc_hs_pkg;

   // Four-phase handshake: IDLE -> REQ (req high) -> REL (req low, wait ack low) -> IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } hs_state_t;

   // Width needed to count up to timeout_cycles. A disabled timeout (0) still
   // gets a 1-bit timer so the port and compare logic stay well-formed.
   function automatic int timer_width(input int timeout_cycles);
      if (timeout_cycles < 1) begin
         return 1;
      end
      return $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/cdc_sync_2ff.sv
// Two-flop level synchronizer for a single asynchronous control bit.
// Latency: 2 clk_in edges from d_async to q_sync.
// Backpressure: none; samples every cycle.
// Ports: clk_in (clock), resetn_in (sync active-low reset), d_async (async level), q_sync (synchronized level).
module cdc_sync_2ff (
   input  logic clk_in,
   input  logic resetn_in,
   input  logic d_async,
   output logic q_sync
);

   logic meta_q;

   always_ff @(posedge clk_in) begin
      if (!resetn_in) begin
         meta_q <= 1'b0;
         q_sync <= 1'b0;
      end else begin
         meta_q <= d_async;
         q_sync <= meta_q;
      end
   end

endmodule

// File: rtl/cdc_handshake_sender.sv
// Source half of a 4-phase req/ack crossing: accepts a word on valid/ready, holds it, raises req, waits for ack rise then fall.
// Latency: req_out rises the cycle after accept; at least 6 cycles per word with an instantly-responding destination.
// Backpressure: evt_ready_out is low outside IDLE and while a stale ack is still seen high; a stuck ack edge is abandoned after TIMEOUT_CYCLES.
// Ports: clk_in/resetn_in (clock, sync active-low reset); evt_valid_in/evt_data_in/evt_ready_out (source word handshake);
//   req_out/data_out/ack_async_in (crossing); busy_out, timeout_out (sticky), drop_count_out (not-ready valid cycles).
// Optional feature macro: CDC_SENDER_DROP_COUNT_EN (drop counter; tied to 0 when undefined).
module cdc_handshake_sender
   import cdc_hs_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                  clk_in,
   input  logic                  resetn_in,
   input  logic                  evt_valid_in,
   input  logic [DATA_WIDTH-1:0] evt_data_in,
   output logic                  evt_ready_out,
   output logic                  req_out,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  ack_async_in,
   output logic                  busy_out,
   output logic                  timeout_out,
   output logic [CNT_WIDTH-1:0]  drop_count_out
);

   localparam int            TW       = timer_width(TIMEOUT_CYCLES);
   // The timer holds k-1 during the k-th cycle spent in a state, so matching
   // TIMEOUT_CYCLES-1 makes the exit edge land exactly TIMEOUT_CYCLES after entry.
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TMR_MAX  = '1;

   hs_state_t     state_q;
   hs_state_t     state_d;
   logic          req_d;
   logic          timeout_set;
   logic          ack_s;
   logic          accept;
   logic          tmo_hit;
   logic [TW-1:0] timer_q;

   cdc_sync_2ff u_ack_sync (
      .clk_in    (clk_in),
      .resetn_in (resetn_in),
      .d_async   (ack_async_in),
      .q_sync    (ack_s)
   );

   // A stale ack seen in IDLE blocks acceptance until it has been synchronized low.
   assign evt_ready_out = (state_q == IDLE) && !ack_s;
   assign accept        = evt_valid_in && evt_ready_out;
   assign busy_out      = (state_q != IDLE);
   assign tmo_hit       = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST);

   always_comb begin
      state_d     = state_q;
      req_d       = req_out;
      timeout_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = REQ;
               req_d   = 1'b1;
            end
         end
         REQ: begin
            if (ack_s) begin
               state_d = REL;
               req_d   = 1'b0;
            end else if (tmo_hit) begin
               // Abandon the word; still pass through REL so a late ack is drained.
               state_d     = REL;
               req_d       = 1'b0;
               timeout_set = 1'b1;
            end
         end
         REL: begin
            if (!ack_s) begin
               state_d = IDLE;
            end else if (tmo_hit) begin
               state_d     = IDLE;
               timeout_set = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!resetn_in) begin
         state_q     <= IDLE;
         req_out     <= 1'b0;
         data_out    <= '0;
         timer_q     <= '0;
         timeout_out <= 1'b0;
      end else begin
         state_q <= state_d;
         req_out <= req_d;
         if (accept) begin
            data_out <= evt_data_in;
         end
         if (timeout_set) begin
            timeout_out <= 1'b1;
         end
         // Restart on every state change; saturate instead of wrapping.
         if (state_d != state_q) begin
            timer_q <= '0;
         end else if ((state_q != IDLE) && (timer_q != TMR_MAX)) begin
            timer_q <= timer_q + 1'b1;
         end
      end
   end

`ifdef CDC_SENDER_DROP_COUNT_EN
   logic [CNT_WIDTH-1:0] drop_q;

   always_ff @(posedge clk_in) begin
      if (!resetn_in) begin
         drop_q <= '0;
      end else if (evt_valid_in && !evt_ready_out && (drop_q != '1)) begin
         drop_q <= drop_q + 1'b1;
      end
   end

   assign drop_count_out = drop_q;
`else
   assign drop_count_out = '0;
`endif

endmodule

// File: tb/tb_cdc_handshake_sender.sv
// Bench for cdc_handshake_sender: directed scenarios plus randomized traffic.
// A background destination agent answers req with ack; a monitor scoreboards accepted words.
// Expected words are queued when offered and popped by the monitor on each accept.
module tb_cdc_handshake_sender;

   localparam int DW  = 32;
   localparam int TMO = 16;
   localparam int CW  = 16;
`ifdef CDC_SENDER_DROP_COUNT_EN
   localparam longint DROP_MAX = (longint'(1) << CW) - 1;
`endif

   logic          clk = 1'b0;
   logic          resetn;
   logic          evt_valid;
   logic [DW-1:0] evt_data;
   logic          evt_ready;
   logic          req;
   logic [DW-1:0] data_o;
   logic          ack_async;
   logic          busy;
   logic          tmo_flag;
   logic [CW-1:0] drop_cnt;

   logic          ack_force;
   logic          ack_agent;
   bit            dest_en;
   bit            agent_rand;
   int            agent_dly;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [DW-1:0] exp_q[$];
   longint        drop_model;

   assign ack_async = ack_force | ack_agent;

   always #5 clk = ~clk;

   cdc_handshake_sender #(
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TMO),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk_in         (clk),
      .resetn_in      (resetn),
      .evt_valid_in   (evt_valid),
      .evt_data_in    (evt_data),
      .evt_ready_out  (evt_ready),
      .req_out        (req),
      .data_out       (data_o),
      .ack_async_in   (ack_async),
      .busy_out       (busy),
      .timeout_out    (tmo_flag),
      .drop_count_out (drop_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Destination agent: raise ack some cycles after seeing req, drop it some cycles after req falls.
   initial begin : dest_agent
      int d;
      ack_agent = 1'b0;
      forever begin
         @(negedge clk);
         if (dest_en && resetn && req && !ack_agent) begin
            d = agent_rand ? int'($urandom_range(0, 4)) : agent_dly;
            repeat (d) @(negedge clk);
            ack_agent = 1'b1;
            for (int i = 0; i < 100 && req; i++) @(negedge clk);
            d = agent_rand ? int'($urandom_range(0, 4)) : agent_dly;
            repeat (d) @(negedge clk);
            ack_agent = 1'b0;
         end
      end
   end

   // Monitor: every accept must yield req rising next cycle with the oldest offered word;
   // data_out may only change on accept; not-ready valid cycles are tallied for the drop counter.
   initial begin : monitor
      logic          prev_acc;
      logic          prev_req;
      logic [DW-1:0] held;
      logic [DW-1:0] w;
      prev_acc   = 1'b0;
      prev_req   = 1'b0;
      held       = '0;
      drop_model = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            prev_acc   = 1'b0;
            prev_req   = 1'b0;
            held       = '0;
            drop_model = 0;
         end else begin
            if (prev_acc) begin
               chk("req_rise_after_accept", 64'({prev_req, req}), 64'(2'b01));
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL scoreboard: accept seen with no offered word outstanding");
               end else begin
                  w    = exp_q.pop_front();
                  held = w;
                  chk("accepted_word", 64'(data_o), 64'(w));
               end
            end else if (req && !prev_req) begin
               n_checks++;
               n_errors++;
               $display("FAIL spurious_req: req_out rose without an accept");
            end
            chk("data_stable", 64'(data_o), 64'(held));
            if (evt_valid && !evt_ready) drop_model++;
            prev_acc = evt_valid && evt_ready;
            prev_req = req;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset(input int cycles);
      @(posedge clk);
      #1 resetn = 1'b0;
      repeat (cycles) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   task automatic offer(input logic [DW-1:0] w);
      exp_q.push_back(w);
      evt_data  = w;
      evt_valid = 1'b1;
   endtask

   // Holds valid until the edge that accepts; returns at that edge +1 with valid dropped.
   task automatic wait_accept(input string name, output longint t_acc);
      bit got;
      got   = 1'b0;
      t_acc = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (evt_ready) begin
            got = 1'b1;
            break;
         end
      end
      n_checks++;
      @(posedge clk);
      t_acc = $time;
      #1;
      if (!got) begin
         n_errors++;
         $display("FAIL %s: word not accepted within 300 cycles", name);
         void'(exp_q.pop_back());
      end
      evt_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!done) begin
         n_errors++;
         $display("FAIL %s: still busy after 100 cycles", name);
      end
   endtask

   task automatic check_drop(input string name);
      longint e;
`ifdef CDC_SENDER_DROP_COUNT_EN
      e = (drop_model > DROP_MAX) ? DROP_MAX : drop_model;
`else
      e = 0;
`endif
      chk(name, 64'(drop_cnt), 64'(e));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_req"},   64'(req),       64'(0));
      chk({tag, "_data"},  64'(data_o),    64'(0));
      chk({tag, "_ready"}, 64'(evt_ready), 64'(1));
      chk({tag, "_busy"},  64'(busy),      64'(0));
      chk({tag, "_tmo"},   64'(tmo_flag),  64'(0));
      chk({tag, "_drop"},  64'(drop_cnt),  64'(0));
   endtask

   initial begin : main
      longint t;
      longint t_acc[5];
      int     k;

      resetn     = 1'b0;
      evt_valid  = 1'b0;
      evt_data   = '0;
      ack_force  = 1'b0;
      dest_en    = 1'b0;
      agent_rand = 1'b0;
      agent_dly  = 3;

      do_reset(2);
      check_reset_values("reset");

      // 1: single word, destination acks 3 cycles after req
      dest_en = 1'b1;
      offer(32'hDEAD_BEEF);
      wait_accept("t1_accept", t);
      chk("t1_req", 64'(req), 64'(1));
      chk("t1_data", 64'(data_o), 64'(32'hDEAD_BEEF));
      wait_idle("t1_idle");
      chk("t1_ready_back", 64'(evt_ready), 64'(1));
      chk("t1_data_held", 64'(data_o), 64'(32'hDEAD_BEEF));
      chk("t1_no_timeout", 64'(tmo_flag), 64'(0));

      // 2: back-to-back words with an instantly-responding destination
      agent_dly = 0;
      for (int i = 1; i <= 4; i++) begin
         offer(DW'(i));
         wait_accept("t2_accept", t_acc[i]);
      end
      wait_idle("t2_idle");
      for (int i = 2; i <= 4; i++) begin
         chk("t2_min_word_spacing", 64'((t_acc[i] - t_acc[i-1]) >= 60), 64'(1));
      end
      check_drop("t2_drop");

      // 3: destination never acks
      dest_en = 1'b0;
      offer(32'h0BAD_F00D);
      wait_accept("t3_accept", t);
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (!req) begin
            k = i;
            break;
         end
      end
      chk("t3_req_fall_cycle", 64'(k), 64'(TMO));
      chk("t3_timeout_set", 64'(tmo_flag), 64'(1));
      @(posedge clk);
      #1;
      chk("t3_back_idle", 64'(busy), 64'(0));
      chk("t3_ready", 64'(evt_ready), 64'(1));
      repeat (3) @(posedge clk);
      #1;
      chk("t3_timeout_sticky", 64'(tmo_flag), 64'(1));

      // 4: ack already high before any request
      do_reset(1);
      chk("t4_timeout_cleared", 64'(tmo_flag), 64'(0));
      ack_force = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("t4_stale_ack_not_ready", 64'(evt_ready), 64'(0));
      offer(32'h4444_0004);
      repeat (100) @(posedge clk);
      #1;
      chk("t4_no_accept_busy", 64'(busy), 64'(0));
      chk("t4_no_accept_req", 64'(req), 64'(0));
      check_drop("t4_drop");
      dest_en   = 1'b1;
      agent_dly = 2;
      ack_force = 1'b0;
      k = 0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk);
         #1;
         if (evt_ready) begin
            k = i;
            break;
         end
      end
      chk("t4_ready_after_release", 64'((k >= 2) && (k <= 3)), 64'(1));
      wait_accept("t4_accept", t);
      wait_idle("t4_idle");

      // 5: reset while in REQ with ack high
      dest_en = 1'b0;
      offer(32'h5555_0005);
      wait_accept("t5_accept", t);
      ack_force = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_in_req", 64'(busy), 64'(1));
      resetn = 1'b0;
      @(posedge clk);
      #1;
      check_reset_values("t5_reset");
      resetn = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("t5_stale_ack_not_ready", 64'(evt_ready), 64'(0));
      offer(32'h5555_0055);
      repeat (10) @(posedge clk);
      #1;
      chk("t5_no_accept", 64'({busy, req}), 64'(0));
      dest_en   = 1'b1;
      ack_force = 1'b0;
      wait_accept("t5_accept_after_release", t);
      wait_idle("t5_idle");

      // random traffic with random destination response times
      agent_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         offer($urandom);
         wait_accept("rnd_accept", t);
      end
      wait_idle("rnd_idle");
      @(posedge clk);
      #1;
      chk("rnd_scoreboard_empty", 64'(exp_q.size()), 64'(0));
      chk("rnd_no_timeout", 64'(tmo_flag), 64'(0));
      chk("rnd_ready", 64'(evt_ready), 64'(1));
      check_drop("rnd_drop");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
